digit_serial_addsub: RTL and testbench
======================================

// Module: digit_serial_addsub
// PURPOSE
//  Parametrised multi-cycle adder/subtractor: adds/subtracts two W-bit operands D bits per clock,
//  LSB digit first, with a registered carry between digits. Successor to the 4-bit ripple-carry adder:
//  any width, selectable digit size, subtract mode, signed-overflow flag, valid/ready handshakes.
//  Sits between operand producers and result consumers where area matters more than latency.
// PARAMETERS
//  W  16  operand/result width in bits; W >= 1
//  D   4  digit width processed per cycle; 1 <= D <= W, W % D == 0 (elaboration error otherwise)
//  N = W/D (derived) number of digit cycles per operation
// PORTS
//  clk        in   1  single clock; all state updates on rising edge
//  rst        in   1  asynchronous, active-high reset
//  in_valid   in   1  operand set offered
//  in_ready   out  1  block can accept operands (high only in IDLE and rst low)
//  x          in   W  operand A (unsigned or two's complement)
//  y          in   W  operand B
//  ci         in   1  carry-in (add) / borrow-in (sub)
//  sub        in   1  0: z = x + y + ci ; 1: z = x - y - ci
//  out_valid  out  1  result held and valid
//  out_ready  in   1  consumer takes result
//  z          out  W  result, mod 2^W
//  co         out  1  final carry-out of MSB (sub: 1 = no borrow, 0 = borrow)
//  ovf        out  1  signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  States: IDLE, RUN, DONE. Reset (async) -> IDLE, digit counter 0, carry reg 0, z=0, co=0, ovf=0,
//   out_valid=0; in_ready=0 while rst high, 1 on the first cycle after release.
//  IDLE: in_ready=1. On edge with in_valid&in_ready: latch x, (sub ? ~y : y), carry = ci ^ sub
//   (sub computes x + ~y + ~ci); counter=0; -> RUN. in_valid without accept changes nothing.
//  RUN: in_ready=0, out_valid=0. Each edge: {c, s} = x_dig + y_dig + c on the low D bits of the operand
//   shift registers; s shifts into result register from MSB side; operands shift right by D;
//   counter++. On the edge processing digit N-1: capture co=c_out, ovf=c_into_MSB ^ c_out, -> DONE.
//  Latency: out_valid rises exactly N cycles after the accept edge (D=W -> 1 cycle).
//  DONE: out_valid=1; z, co, ovf stable until out_ready sampled high; in_valid ignored, in_ready=0.
//   On edge with out_ready=1 -> IDLE, out_valid=0 next cycle; z/co/ovf retain last result.
//   out_ready high before DONE has no effect. No overlap: next accept earliest one cycle after release.
//  z during RUN shows partial shift contents and is not valid; consumers qualify with out_valid.
//  Wrap-around: result mod 2^W; all-ones + 1 gives z=0, co=1. Carry chain spans digits via carry reg;
//   carry register width 1 regardless of D.
//  Reset mid-operation: aborts immediately, all outputs to reset values, partial result discarded.
//  sub/ci/x/y sampled only at accept; changes while RUN/DONE are ignored.
// TESTING (W=16, D=4 unless noted)
//  1 add x=0x1234 y=0x4321 ci=0 -> z=0x5555 co=0 ovf=0; out_valid exactly 4 cycles after accept.
//  2 add x=0xFFFF y=0x0001 -> z=0x0000 co=1 ovf=0; x=0x7FFF y=0x0001 -> z=0x8000 co=0 ovf=1.
//  3 sub x=0x0005 y=0x0007 ci=0 -> z=0xFFFE co=0 ovf=0; x=0x8000 y=0x0001 -> z=0x7FFF co=1 ovf=1.
//  4 hold out_ready=0 for 5 cycles in DONE with in_valid=1 -> z/co/ovf stable, in_ready=0, no accept.
//  5 rst pulse after 2 RUN cycles -> outputs 0 at once, IDLE; next op x=0x0001 y=0x0002 -> z=0x0003.
//  6 W=4 with D=1, D=2, D=4: all 512 {x,y,ci} per sub value vs behavioural model; latency = 4/2/1.

Source files
------------

// File: rtl/digit_serial_addsub_if.sv
// Operand/result handshake bundle for the digit-serial adder/subtractor.
// The master side drives operands and out_ready; the slave side is the arithmetic block.
interface digit_serial_addsub_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         ci;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
  logic         co;
  logic         ovf;

  modport master (
    output in_valid, x, y, ci, sub, out_ready,
    input  in_ready, out_valid, z, co, ovf
  );

  modport slave (
    input  in_valid, x, y, ci, sub, out_ready,
    output in_ready, out_valid, z, co, ovf
  );
endinterface

// File: rtl/digit_serial_addsub.sv
// Multi-cycle W-bit adder/subtractor processing D bits per clock, LSB digit first,
// with a one-bit carry register chaining the digits together.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | one digit per edge, N edges total
// DONE  | result held with out_valid until out_ready
module digit_serial_addsub #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  digit_serial_addsub_if.slave bus
);
  localparam int N  = (D >= 1) ? (W / D) : 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (D < 1 || D > W || (W % D) != 0) begin : g_bad_params
    $error("digit_serial_addsub: D must satisfy 1 <= D <= W and divide W");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  xs_q, xs_d;
  logic [W-1:0]  ys_q, ys_d;
  logic [W-1:0]  zs_q, zs_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;

  logic [D-1:0]  x_dig;
  logic [D-1:0]  y_dig;
  logic [D:0]    dsum;
  logic          c_into_msb;
  logic [W-1:0]  s_ext;

  assign x_dig = xs_q[D-1:0];
  assign y_dig = ys_q[D-1:0];
  assign dsum  = {1'b0, x_dig} + {1'b0, y_dig} + {{D{1'b0}}, carry_q};
  // Carry into the top bit of this digit, recovered from the sum bit; only
  // meaningful on the last digit, where it is the carry into the word MSB.
  assign c_into_msb = x_dig[D-1] ^ y_dig[D-1] ^ dsum[D-1];
  assign s_ext      = W'(dsum[D-1:0]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    xs_d    = xs_q;
    ys_d    = ys_q;
    zs_d    = zs_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // Subtraction is x + ~y + ~borrow, so invert y and the carry-in here.
          xs_d    = bus.x;
          ys_d    = bus.sub ? ~bus.y : bus.y;
          carry_d = bus.ci ^ bus.sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        xs_d    = xs_q >> D;
        ys_d    = ys_q >> D;
        zs_d    = (zs_q >> D) | (s_ext << (W - D));
        carry_d = dsum[D];
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          co_d    = dsum[D];
          ovf_d   = c_into_msb ^ dsum[D];
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      xs_q    <= '0;
      ys_q    <= '0;
      zs_q    <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      xs_q    <= xs_d;
      ys_q    <= ys_d;
      zs_q    <= zs_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.z         = zs_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Directed bench for digit_serial_addsub: W=16/D=4 scenarios plus an exhaustive
// W=4 sweep across D=1, 2 and 4 against a signed/unsigned arithmetic model.
module tb_digit_serial_addsub;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  digit_serial_addsub_if #(.W(16)) bus ();
  digit_serial_addsub #(.W(16), .D(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [3:0] s_x = '0, s_y = '0;
  logic       s_ci = 1'b0, s_sub = 1'b0, s_iv = 1'b0, s_or = 1'b0;

  digit_serial_addsub_if #(.W(4)) b1 ();
  digit_serial_addsub_if #(.W(4)) b2 ();
  digit_serial_addsub_if #(.W(4)) b4 ();

  assign b1.in_valid = s_iv;  assign b1.x = s_x;  assign b1.y = s_y;
  assign b1.ci = s_ci;        assign b1.sub = s_sub; assign b1.out_ready = s_or;
  assign b2.in_valid = s_iv;  assign b2.x = s_x;  assign b2.y = s_y;
  assign b2.ci = s_ci;        assign b2.sub = s_sub; assign b2.out_ready = s_or;
  assign b4.in_valid = s_iv;  assign b4.x = s_x;  assign b4.y = s_y;
  assign b4.ci = s_ci;        assign b4.sub = s_sub; assign b4.out_ready = s_or;

  digit_serial_addsub #(.W(4), .D(1)) d1 (.clk(clk), .rst(rst), .bus(b1));
  digit_serial_addsub #(.W(4), .D(2)) d2 (.clk(clk), .rst(rst), .bus(b2));
  digit_serial_addsub #(.W(4), .D(4)) d4 (.clk(clk), .rst(rst), .bus(b4));

  // Offer one operand set, scramble the inputs right after the accept edge,
  // and return the number of edges until out_valid (ends on a falling edge).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic c, input logic s, output int lat);
    @(negedge clk);
    bus.x = a; bus.y = b; bus.ci = c; bus.sub = s; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0; bus.x = ~a; bus.y = ~b; bus.ci = ~c; bus.sub = ~s;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.y = '0; bus.ci = 1'b0; bus.sub = 1'b0;
    #12;
    checks++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready);
    checks++;
    if ({bus.out_valid, bus.z, bus.co, bus.ovf} !== 19'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b z=%h co=%b ovf=%b exp all 0",
               bus.out_valid, bus.z, bus.co, bus.ovf);
    end
    if (bus.in_ready !== 1'b0) errors++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    logic [15:0] vx[4] = '{16'h1234, 16'h1234, 16'hFFFF, 16'h7FFF};
    logic [15:0] vy[4] = '{16'h4321, 16'h4321, 16'h0001, 16'h0001};
    logic        vc[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [17:0] ve[4] = '{{16'h5555, 2'b00}, {16'h5556, 2'b00},
                          {16'h0000, 2'b10}, {16'h8000, 2'b01}};
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(vx[i], vy[i], vc[i], 1'b0, lat);
      checks++;
      if ({bus.z, bus.co, bus.ovf} !== ve[i] || lat != 4) begin
        errors++;
        $display("FAIL add_%0d got z=%h co=%b ovf=%b lat=%0d exp z=%h co=%b ovf=%b lat=4",
                 i, bus.z, bus.co, bus.ovf, lat, ve[i][17:2], ve[i][1], ve[i][0]);
      end
      release_result();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || {bus.z, bus.co, bus.ovf} !== ve[i]) begin
        errors++;
        $display("FAIL add_release_%0d got valid=%b ready=%b z=%h exp valid=0 ready=1 z=%h",
                 i, bus.out_valid, bus.in_ready, bus.z, ve[i][17:2]);
      end
    end
  endtask

  task automatic test_sub();
    logic [15:0] vx[3] = '{16'h0005, 16'h8000, 16'h0010};
    logic [15:0] vy[3] = '{16'h0007, 16'h0001, 16'h0001};
    logic        vc[3] = '{1'b0, 1'b0, 1'b1};
    logic [17:0] ve[3] = '{{16'hFFFE, 2'b00}, {16'h7FFF, 2'b11}, {16'h000E, 2'b10}};
    int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(vx[i], vy[i], vc[i], 1'b1, lat);
      checks++;
      if ({bus.z, bus.co, bus.ovf} !== ve[i] || lat != 4) begin
        errors++;
        $display("FAIL sub_%0d got z=%h co=%b ovf=%b lat=%0d exp z=%h co=%b ovf=%b lat=4",
                 i, bus.z, bus.co, bus.ovf, lat, ve[i][17:2], ve[i][1], ve[i][0]);
      end
      release_result();
    end
  endtask

  task automatic test_hold();
    int lat;
    do_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.z, bus.co, bus.ovf} !== {16'h1000, 2'b00} || lat != 4) begin
      errors++;
      $display("FAIL hold_result got z=%h co=%b ovf=%b lat=%0d exp z=1000 co=0 ovf=0 lat=4",
               bus.z, bus.co, bus.ovf, lat);
    end
    bus.x = 16'hAAAA; bus.y = 16'h5555; bus.in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus.z, bus.co, bus.ovf} !== {16'h1000, 2'b00} || bus.out_valid !== 1'b1 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle_%0d got z=%h co=%b ovf=%b valid=%b ready=%b exp z=1000 co=0 ovf=0 valid=1 ready=0",
                 c, bus.z, bus.co, bus.ovf, bus.out_valid, bus.in_ready);
      end
    end
    bus.in_valid = 1'b0;
    release_result();
    do_op(16'h0002, 16'h0003, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.z, bus.co, bus.ovf} !== {16'h0005, 2'b00} || lat != 4) begin
      errors++;
      $display("FAIL hold_next_op got z=%h lat=%0d exp z=0005 lat=4", bus.z, lat);
    end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.out_ready = 1'b1;
    do_op(16'h0100, 16'h0200, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.z, bus.co, bus.ovf} !== {16'h0300, 2'b00} || lat != 4) begin
      errors++;
      $display("FAIL b2b_first got z=%h lat=%0d exp z=0300 lat=4", bus.z, lat);
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_release got valid=%b ready=%b exp valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    do_op(16'h0FFF, 16'h0001, 1'b1, 1'b1, lat);
    checks++;
    if ({bus.z, bus.co, bus.ovf} !== {16'h0FFD, 2'b10} || lat != 4) begin
      errors++;
      $display("FAIL b2b_second got z=%h co=%b ovf=%b lat=%0d exp z=0ffd co=1 ovf=0 lat=4",
               bus.z, bus.co, bus.ovf, lat);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    @(negedge clk);
    bus.x = 16'h1111; bus.y = 16'h2222; bus.ci = 1'b0; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.out_valid, bus.in_ready, bus.z, bus.co, bus.ovf} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid got valid=%b ready=%b z=%h co=%b ovf=%b exp all 0",
               bus.out_valid, bus.in_ready, bus.z, bus.co, bus.ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release got ready=%b valid=%b exp ready=1 valid=0",
               bus.in_ready, bus.out_valid);
    end
    do_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat);
    checks++;
    if ({bus.z, bus.co, bus.ovf} !== {16'h0003, 2'b00} || lat != 4) begin
      errors++;
      $display("FAIL reset_mid_next got z=%h co=%b ovf=%b lat=%0d exp z=0003 co=0 ovf=0 lat=4",
               bus.z, bus.co, bus.ovf, lat);
    end
    release_result();
  endtask

  task automatic test_w4_sweep();
    int r, sx, sy, sr, l1, l2, l4;
    logic [3:0] ez;
    logic eco, eovf;
    for (int s = 0; s < 2; s++) begin
      for (int v = 0; v < 512; v++) begin
        @(negedge clk);
        s_x = 4'((v >> 5) & 15); s_y = 4'((v >> 1) & 15); s_ci = v[0]; s_sub = s[0];
        s_iv = 1'b1;
        sx = s_x[3] ? int'(s_x) - 16 : int'(s_x);
        sy = s_y[3] ? int'(s_y) - 16 : int'(s_y);
        if (s == 0) begin
          r   = int'(s_x) + int'(s_y) + int'(s_ci);
          sr  = sx + sy + int'(s_ci);
          eco = (r > 15);
        end else begin
          r   = int'(s_x) - int'(s_y) - int'(s_ci);
          sr  = sx - sy - int'(s_ci);
          eco = (r >= 0);
        end
        ez   = r[3:0];
        eovf = (sr > 7) || (sr < -8);
        @(posedge clk);
        @(negedge clk);
        s_iv = 1'b0; s_x = ~s_x; s_y = ~s_y; s_ci = ~s_ci; s_sub = ~s_sub;
        l1 = -1; l2 = -1; l4 = -1;
        for (int c = 0; c < 6; c++) begin
          if (b1.out_valid && l1 < 0) l1 = c;
          if (b2.out_valid && l2 < 0) l2 = c;
          if (b4.out_valid && l4 < 0) l4 = c;
          @(posedge clk);
          @(negedge clk);
        end
        checks++;
        if ({b1.z, b1.co, b1.ovf} !== {ez, eco, eovf} || l1 != 4) begin
          errors++;
          $display("FAIL w4_d1 sub=%0d v=%0d got z=%h co=%b ovf=%b lat=%0d exp z=%h co=%b ovf=%b lat=4",
                   s, v, b1.z, b1.co, b1.ovf, l1, ez, eco, eovf);
        end
        checks++;
        if ({b2.z, b2.co, b2.ovf} !== {ez, eco, eovf} || l2 != 2) begin
          errors++;
          $display("FAIL w4_d2 sub=%0d v=%0d got z=%h co=%b ovf=%b lat=%0d exp z=%h co=%b ovf=%b lat=2",
                   s, v, b2.z, b2.co, b2.ovf, l2, ez, eco, eovf);
        end
        checks++;
        if ({b4.z, b4.co, b4.ovf} !== {ez, eco, eovf} || l4 != 1) begin
          errors++;
          $display("FAIL w4_d4 sub=%0d v=%0d got z=%h co=%b ovf=%b lat=%0d exp z=%h co=%b ovf=%b lat=1",
                   s, v, b4.z, b4.co, b4.ovf, l4, ez, eco, eovf);
        end
        s_or = 1'b1;
        @(posedge clk);
        @(negedge clk);
        s_or = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    test_w4_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
